router_wr_ctrl: RTL and testbench

- Packet write controller between the router input port and the three per-destination output FIFOs (router_FIFO x3).
- Decodes the header, steers bytes to one FIFO with write_enb/lfd_state, and stalls the source with busy while the target FIFO is full.
- Checks end-of-packet parity and drops packets with address 2'b11.
- Runs a per-port read timeout that issues soft_reset to a FIFO whose consumer stops reading.

---
 rtl/router_pkg.sv | 13 +
 rtl/router_wr_ctrl_if.sv | 28 ++
 rtl/router_port_timer.sv | 43 ++++
 rtl/router_wr_ctrl.sv | 123 ++++++++++++
 tb/tb_router_wr_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the router write controller.
package router_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, DROP} state_e;

   localparam logic [1:0]  ADDR_INVALID    = 2'b11;
   localparam int unsigned LEN_MSB         = 7;
   localparam int unsigned LEN_LSB         = 2;
   localparam int unsigned ADDR_MSB        = 1;
   localparam int unsigned DEFAULT_TIMEOUT = 30;
   localparam int unsigned REM_W           = 7;

endpackage

// File: rtl/router_wr_ctrl_if.sv
// Packet source / FIFO-side signal bundle of the router write controller.
interface router_wr_ctrl_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned NPORTS = 3
);
   logic              pkt_valid;
   logic [DATA_W-1:0] data_in;
   logic [NPORTS-1:0] fifo_full;
   logic [NPORTS-1:0] fifo_empty;
   logic [NPORTS-1:0] read_enb;
   logic [NPORTS-1:0] write_enb;
   logic              lfd_state;
   logic [DATA_W-1:0] data_out;
   logic              busy;
   logic [NPORTS-1:0] vld_out;
   logic [NPORTS-1:0] soft_reset;
   logic              err;

   modport master (
      output pkt_valid, data_in, fifo_full, fifo_empty, read_enb,
      input  write_enb, lfd_state, data_out, busy, vld_out, soft_reset, err
   );

   modport slave (
      input  pkt_valid, data_in, fifo_full, fifo_empty, read_enb,
      output write_enb, lfd_state, data_out, busy, vld_out, soft_reset, err
   );
endinterface

// File: rtl/router_port_timer.sv
// Per-port read timeout: pulses soft_reset when pending data goes unread for TIMEOUT cycles.
module router_port_timer #(
   parameter int unsigned TIMEOUT = 30
) (
   input  logic clock,
   input  logic resetn,
   input  logic vld,
   input  logic read_enb,
   output logic soft_reset
);
   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            pulse_q, pulse_d;
   logic            counting;

   assign counting = vld && !read_enb;

   always_comb begin
      cnt_d   = '0;
      pulse_d = 1'b0;
      if (counting) begin
         if (cnt_q == CntW'(TIMEOUT - 1)) begin
            pulse_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
      end
   end

   assign soft_reset = pulse_q;

endmodule

// File: rtl/router_wr_ctrl.sv
// Router write controller: header decode, FIFO steering, parity check, per-port read timeout.
module router_wr_ctrl
   import router_pkg::*;
#(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
   parameter int unsigned NPORTS  = 3
) (
   input logic              clock,
   input logic              resetn,
   router_wr_ctrl_if.slave  bus
);
   state_e             state_q, state_d;
   logic [1:0]         dest_q, dest_d;
   logic [REM_W-1:0]   rem_q, rem_d;
   logic [DATA_W-1:0]  par_q, par_d;
   logic               err_q, err_d;
   logic [NPORTS-1:0]  write_enb, soft_reset;
   logic               lfd_state, busy;
   logic [1:0]         addr;
   logic [LEN_MSB-LEN_LSB:0] len;

   assign addr = bus.data_in[ADDR_MSB:0];
   assign len  = bus.data_in[LEN_MSB:LEN_LSB];

   for (genvar i = 0; i < NPORTS; i++) begin : g_timer
      router_port_timer #(
         .TIMEOUT (TIMEOUT)
      ) u_timer (
         .clock      (clock),
         .resetn     (resetn),
         .vld        (!bus.fifo_empty[i]),
         .read_enb   (bus.read_enb[i]),
         .soft_reset (soft_reset[i])
      );
   end

   always_comb begin
      state_d   = state_q;
      dest_d    = dest_q;
      rem_d     = rem_q;
      par_d     = par_q;
      err_d     = 1'b0;
      write_enb = '0;
      lfd_state = 1'b0;
      busy      = 1'b0;
      unique case (state_q)
         IDLE: begin
            busy = bus.pkt_valid && (addr != ADDR_INVALID) && bus.fifo_full[addr];
            if (bus.pkt_valid && !busy) begin
               rem_d = {1'b0, len} + 1'b1;
               if (addr != ADDR_INVALID) begin
                  write_enb[addr] = 1'b1;
                  lfd_state       = 1'b1;
                  dest_d          = addr;
                  par_d           = bus.data_in;
                  state_d         = LOAD;
               end else begin
                  state_d = DROP;
               end
            end
         end
         LOAD: begin
            // Target FIFO is being flushed: discard from this byte on, no parity error.
            if (soft_reset[dest_q]) begin
               state_d = DROP;
               if (bus.pkt_valid) begin
                  rem_d = rem_q - 1'b1;
                  if (rem_q == REM_W'(1)) state_d = IDLE;
               end
            end else begin
               busy = bus.fifo_full[dest_q];
               if (bus.pkt_valid && !busy) begin
                  write_enb[dest_q] = 1'b1;
                  par_d             = par_q ^ bus.data_in;
                  rem_d             = rem_q - 1'b1;
                  if (rem_q == REM_W'(1)) begin
                     state_d = IDLE;
                     err_d   = (par_q ^ bus.data_in) != '0;
                  end
               end
            end
         end
         DROP: begin
            if (bus.pkt_valid) begin
               rem_d = rem_q - 1'b1;
               if (rem_q == REM_W'(1)) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (!resetn) begin
         write_enb = '0;
         lfd_state = 1'b0;
         busy      = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q <= IDLE;
         dest_q  <= '0;
         rem_q   <= '0;
         par_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dest_q  <= dest_d;
         rem_q   <= rem_d;
         par_q   <= par_d;
         err_q   <= err_d;
      end
   end

   assign bus.write_enb  = write_enb;
   assign bus.lfd_state  = lfd_state;
   assign bus.busy       = busy;
   assign bus.data_out   = bus.data_in;
   assign bus.vld_out    = ~bus.fifo_empty;
   assign bus.soft_reset = soft_reset;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_router_wr_ctrl.sv
// Directed bench for router_wr_ctrl; FIFO writes are checked against a scoreboard queue.
module tb_router_wr_ctrl;
   import router_pkg::*;

   typedef struct {
      logic [1:0] port;
      logic [7:0] data;
      logic       lfd;
   } exp_t;

   logic clock = 1'b0;
   logic resetn;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   router_wr_ctrl_if #(.DATA_W(8), .NPORTS(3)) bus ();

   router_wr_ctrl #(
      .DATA_W  (8),
      .TIMEOUT (30),
      .NPORTS  (3)
   ) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Writes are visible mid-cycle and commit on the following rising edge.
   always @(negedge clock) begin
      if (|bus.write_enb) begin
         if (sb.size() == 0) begin
            chk("unexpected_write", {20'h0, bus.write_enb, 1'b0, bus.data_out}, 32'h0);
         end else begin
            exp_t       e;
            logic [2:0] oh;
            e  = sb.pop_front();
            oh = 3'b001 << e.port;
            chk("fifo_write", {20'h0, bus.lfd_state, bus.write_enb, bus.data_out},
                {20'h0, e.lfd, oh, e.data});
         end
      end else begin
         chk("lfd_idle", {31'h0, bus.lfd_state}, 32'h0);
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit wr, input logic [1:0] port,
                            input bit lfd);
      int n = 0;
      bus.pkt_valid = 1'b1;
      bus.data_in   = b;
      if (wr) sb.push_back('{port, b, lfd});
      #1;
      if (!wr) chk("drop_busy", {31'h0, bus.busy}, 32'h0);
      while (bus.busy && n < 20) begin
         tick();
         n++;
      end
      if (n == 20) chk("busy_timeout", 32'(n), 32'h0);
      tick();
      bus.pkt_valid = 1'b0;
   endtask

   task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] pl [8], input int n,
                           input bit bad_par);
      logic [7:0] par;
      logic [1:0] a;
      bit         wr;
      a   = hdr[1:0];
      wr  = (a != 2'b11);
      par = hdr;
      send_byte(hdr, wr, a, 1'b1);
      for (int i = 0; i < n; i++) begin
         send_byte(pl[i], wr, a, 1'b0);
         par = par ^ pl[i];
      end
      send_byte(bad_par ? ~par : par, wr, a, 1'b0);
      chk("err_pulse", {31'h0, bus.err}, {31'h0, bad_par && wr});
      chk("state_idle", 32'(dut.state_q), 32'(IDLE));
      tick();
      chk("err_clear", {31'h0, bus.err}, 32'h0);
      chk("sb_drain", 32'(sb.size()), 32'h0);
   endtask

   initial begin
      logic [7:0] pl [8];
      logic [7:0] par;

      resetn         = 1'b0;
      bus.pkt_valid  = 1'b1;
      bus.data_in    = 8'h11;
      bus.fifo_full  = 3'b000;
      bus.fifo_empty = 3'b111;
      bus.read_enb   = 3'b000;
      tick();
      tick();
      chk("rst_write_enb", {29'h0, bus.write_enb}, 32'h0);
      chk("rst_busy", {31'h0, bus.busy}, 32'h0);
      chk("rst_err", {31'h0, bus.err}, 32'h0);
      chk("rst_soft_reset", {29'h0, bus.soft_reset}, 32'h0);
      chk("rst_vld_out", {29'h0, bus.vld_out}, 32'h0);
      chk("rst_state", 32'(dut.state_q), 32'(IDLE));
      bus.pkt_valid = 1'b0;
      resetn        = 1'b1;
      tick();

      // Good packet to port 1, then the same packet with a corrupted parity byte.
      pl = '{8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00};
      send_pkt(8'h11, pl, 4, 1'b0);
      send_pkt(8'h11, pl, 4, 1'b1);

      // Address 3 is dropped, the following packet goes through.
      pl = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      send_pkt(8'h0B, pl, 2, 1'b0);
      pl = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      send_pkt(8'h05, pl, 1, 1'b0);
      send_pkt(8'h00, pl, 0, 1'b0);

      // Port 2 goes full on the third payload byte for four cycles.
      par = 8'h12;
      send_byte(8'h12, 1'b1, 2'd2, 1'b1);
      send_byte(8'h11, 1'b1, 2'd2, 1'b0);
      send_byte(8'h22, 1'b1, 2'd2, 1'b0);
      par = par ^ 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44;
      bus.fifo_full = 3'b100;
      bus.pkt_valid = 1'b1;
      bus.data_in   = 8'h33;
      sb.push_back('{2'd2, 8'h33, 1'b0});
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("full_busy", {31'h0, bus.busy}, 32'h1);
         chk("full_no_write", {29'h0, bus.write_enb}, 32'h0);
         tick();
      end
      bus.fifo_full = 3'b000;
      #1;
      chk("unfull_busy", {31'h0, bus.busy}, 32'h0);
      chk("unfull_write", {29'h0, bus.write_enb}, 32'h4);
      tick();
      send_byte(8'h44, 1'b1, 2'd2, 1'b0);
      send_byte(par, 1'b1, 2'd2, 1'b0);
      chk("full_pkt_err", {31'h0, bus.err}, 32'h0);
      chk("full_pkt_drain", 32'(sb.size()), 32'h0);
      tick();

      // Port 0 holds data with no reader.
      bus.fifo_empty = 3'b110;
      #1;
      chk("vld_out", {29'h0, bus.vld_out}, 32'h1);
      for (int i = 1; i <= 31; i++) begin
         tick();
         chk("timeout_plain", {29'h0, bus.soft_reset}, (i == 30) ? 32'h1 : 32'h0);
      end
      bus.fifo_empty = 3'b111;
      tick();
      bus.fifo_empty = 3'b110;
      for (int i = 1; i <= 52; i++) begin
         if (i == 20) bus.read_enb = 3'b001;
         tick();
         bus.read_enb = 3'b000;
         chk("timeout_read", {29'h0, bus.soft_reset}, (i == 50) ? 32'h1 : 32'h0);
      end
      bus.fifo_empty = 3'b111;
      tick();

      // Reset lands on the second payload byte of a port-0 packet.
      send_byte(8'h08, 1'b1, 2'd0, 1'b1);
      send_byte(8'h77, 1'b1, 2'd0, 1'b0);
      bus.pkt_valid = 1'b1;
      bus.data_in   = 8'h88;
      resetn        = 1'b0;
      #1;
      chk("rst_mid_write", {29'h0, bus.write_enb}, 32'h0);
      chk("rst_mid_busy", {31'h0, bus.busy}, 32'h0);
      tick();
      chk("rst_mid_state", 32'(dut.state_q), 32'(IDLE));
      chk("rst_mid_err", {31'h0, bus.err}, 32'h0);
      resetn        = 1'b1;
      bus.pkt_valid = 1'b0;
      pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00};
      send_pkt(8'h12, pl, 4, 1'b0);

      tick();
      chk("final_drain", 32'(sb.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

endmodule
